// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: drives s/r of an external clocked SR flip-flop on request and confirms q/qbar feedback.
// Optional CHECK timeout is compiled in when the macro SR_DRV_TIMEOUT_EN is defined.
module sr_drive_ctrl #(
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  input  logic       q_fb,
  input  logic       qbar_fb,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CHECK, ST_RESP} state_t;

  localparam logic [1:0] OP_HOLD      = 2'b00;
  localparam logic [1:0] OP_SET       = 2'b01;
  localparam logic [1:0] OP_TOGGLE    = 2'b11;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_FEEDBACK = 2'b10;
  localparam logic [3:0] PULSE_LOAD   = 4'(PULSE_CYCLES - 1);

  state_t     r_state;
  logic       r_target;
  logic [3:0] r_pulse_cnt;
  logic       r_s;
  logic       r_r;
  logic       r_done;
  logic       r_err;
  logic [1:0] r_err_code;

  logic w_new_target;
  logic w_fb_bad;
  logic w_fb_match;
  logic w_timeout;

  assign w_new_target = (req_op == OP_SET) || ((req_op == OP_TOGGLE) && !q_fb);
  assign w_fb_bad     = (q_fb == qbar_fb);
  assign w_fb_match   = (q_fb == r_target);

`ifdef SR_DRV_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_check_cnt;

  // Counts cycles spent in CHECK; cleared in every other state so each command starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_check_cnt <= '0;
    end else if (r_state == ST_CHECK) begin
      r_check_cnt <= r_check_cnt + 8'd1;
    end else begin
      r_check_cnt <= '0;
    end
  end

  assign w_timeout = (r_check_cnt == TIMEOUT_LAST);
`else
  // Without the timeout feature CHECK waits for a match or an inconsistency forever.
  assign w_timeout = 1'b0 && (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_target    <= 1'b0;
      r_pulse_cnt <= '0;
      r_s         <= 1'b0;
      r_r         <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_err_code <= ERR_NONE;
            if (req_op == OP_HOLD) begin
              r_state <= ST_RESP;
              r_done  <= 1'b1;
            end else begin
              r_target    <= w_new_target;
              r_s         <= w_new_target;
              r_r         <= !w_new_target;
              r_pulse_cnt <= PULSE_LOAD;
              r_state     <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          if (r_pulse_cnt == 4'd0) begin
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_state <= ST_CHECK;
          end else begin
            r_pulse_cnt <= r_pulse_cnt - 4'd1;
          end
        end
        // Inconsistent feedback outranks a match, which outranks a timeout.
        ST_CHECK: begin
          if (w_fb_bad) begin
            r_err_code <= ERR_FEEDBACK;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
            r_state    <= ST_RESP;
          end else if (w_fb_match) begin
            r_done  <= 1'b1;
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_err_code <= ERR_TIMEOUT;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign s         = r_s;
  assign r         = r_r;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: directed and random stimulus against a cycle-timestamp reference model
// of sr_drive_ctrl, with a behavioural SR flip-flop and switchable faulty feedback.
`timescale 1ns/1ps
module tb_sr_drive_ctrl;

  localparam int P   = 1;
  localparam int TMO = 4;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic       req_ready;
  logic       q_fb;
  logic       qbar_fb;
  logic       s;
  logic       r;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  // Feedback source: 0 = ideal flip-flop, 1 = stuck q=0/qbar=1, 2 = inconsistent q=qbar=1.
  logic ffQ = 1'b0;
  int   fbMode = 0;

  int evalCount = 0;
  int failCount = 0;
  int cyc = 0;

  // Reference model: one in-flight command described by its accept and completion cycles.
  bit         inflight = 1'b0;
  bit         isHold = 1'b0;
  bit         tgt = 1'b0;
  bit         errExp = 1'b0;
  logic [1:0] codeExp = 2'b00;
  int         acceptCyc = -100;
  int         doneCyc = -1;
  bit         expS, expR, expDone, expErr, expBusy, expReady;
  int         acceptCount = 0;
  int         doneSeen = 0;

  sr_drive_ctrl #(.PULSE_CYCLES(P), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .q_fb(q_fb), .qbar_fb(qbar_fb), .s(s), .r(r),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Ideal clocked SR flip-flop: q follows the edge that samples s/r.
  always @(posedge clk) begin
    if (s) ffQ <= 1'b1;
    else if (r) ffQ <= 1'b0;
  end

  assign q_fb    = (fbMode == 0) ? ffQ : (fbMode == 2);
  assign qbar_fb = (fbMode == 0) ? ~ffQ : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evalCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit pulseWin;
    pulseWin = inflight && !isHold && (cyc >= acceptCyc + 1) && (cyc <= acceptCyc + P);
    expS     = pulseWin && tgt;
    expR     = pulseWin && !tgt;
    expDone  = inflight && (cyc == doneCyc);
    expErr   = expDone && errExp;
    expBusy  = inflight;
    expReady = !inflight;
    chk("s", s, expS);
    chk("r", r, expR);
    chk("s_and_r", s & r, 0);
    chk("req_ready", req_ready, expReady);
    chk("busy", busy, expBusy);
    chk("done", done, expDone);
    chk("err", err, expErr);
    chk("err_code", err_code, codeExp);
    if (expDone && !errExp && !isHold && fbMode == 0) chk("q_after_cmd", ffQ, tgt);
    if (done === 1'b1) doneSeen++;
  endtask

  task automatic modelAdvance();
    if (reset) begin
      inflight = 1'b0;
      doneCyc  = -1;
      codeExp  = 2'b00;
      errExp   = 1'b0;
      return;
    end
    if (inflight && cyc == doneCyc) begin
      inflight = 1'b0;
    end else if (inflight && doneCyc < 0 && cyc >= acceptCyc + P + 1) begin
      if (q_fb === qbar_fb) begin
        doneCyc = cyc + 1; errExp = 1'b1; codeExp = 2'b10;
      end else if (q_fb === tgt) begin
        doneCyc = cyc + 1;
      end
`ifdef SR_DRV_TIMEOUT_EN
      else if (cyc - (acceptCyc + P + 1) + 1 >= TMO) begin
        doneCyc = cyc + 1; errExp = 1'b1; codeExp = 2'b01;
      end
`endif
    end
    if (req_valid && expReady) begin
      inflight  = 1'b1;
      acceptCyc = cyc;
      acceptCount++;
      codeExp   = 2'b00;
      errExp    = 1'b0;
      isHold    = (req_op == OP_HOLD);
      if (req_op == OP_SET) tgt = 1'b1;
      else if (req_op == OP_CLEAR) tgt = 1'b0;
      else if (req_op == OP_TOGGLE) tgt = ~q_fb;
      doneCyc   = isHold ? cyc + 1 : -1;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input logic [1:0] op, input int mode);
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
    reset     = rst;
    req_valid = v;
    req_op    = op;
    fbMode    = mode;
    #1;
    modelAdvance();
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, OP_HOLD, mode);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;

    idle(2, 0);

    applyStimulus(1'b0, 1'b1, OP_SET, 0);
    idle(4, 0);

    applyStimulus(1'b0, 1'b1, OP_TOGGLE, 0);
    idle(4, 0);
    applyStimulus(1'b0, 1'b1, OP_TOGGLE, 0);
    idle(4, 0);

    applyStimulus(1'b0, 1'b1, OP_CLEAR, 0);
    idle(4, 0);
    applyStimulus(1'b0, 1'b1, OP_HOLD, 0);
    idle(2, 0);

    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? OP_SET : OP_CLEAR, 0);
    idle(4, 0);

    applyStimulus(1'b0, 1'b1, OP_SET, 1);
    idle(2, 1);
    idle(1, 2);
    idle(3, 0);
    applyStimulus(1'b0, 1'b1, OP_HOLD, 0);
    idle(2, 0);

`ifdef SR_DRV_TIMEOUT_EN
    applyStimulus(1'b0, 1'b1, OP_SET, 1);
    idle(8, 1);
    idle(2, 0);
`endif

    applyStimulus(1'b0, 1'b1, OP_CLEAR, 0);
    applyStimulus(1'b1, 1'b0, OP_HOLD, 0);
    idle(4, 0);

    applyStimulus(1'b0, 1'b1, OP_SET, 1);
    idle(2, 1);
    applyStimulus(1'b1, 1'b0, OP_HOLD, 1);
    idle(4, 0);

    acceptCount = 0;
    doneSeen    = 0;
    for (int i = 0; i < 2000; i++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0);
    idle(10, 0);
    chk("done_per_accept", doneSeen, acceptCount);

    $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
    $finish;
  end

endmodule

// File: doc/sr_drive_ctrl.md
# sr_drive_ctrl

Request-driven controller that drives the `s`/`r` inputs of an external clocked SR flip-flop (`sr_ff`) and confirms the result on its `q`/`qbar` feedback. It accepts set, clear, toggle and hold commands over a valid/ready handshake. It emits legal, non-overlapping `s`/`r` pulses, never `s=r=1`. It reports completion or error per command. It sits between control logic and `sr_ff`, owning the drive side of that interface.

## Interface

Parameters:
- `PULSE_CYCLES`, default 1: cycles `s` or `r` is held high per command; legal range 1–15.
- `TIMEOUT`, default 8: maximum cycles spent in CHECK before a timeout error; legal range 1–255. Used only with `SR_DRV_TIMEOUT_EN`.

Ports:
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, 1 bit: command present.
- `req_op` input, 2 bits: 00 hold, 01 set, 10 clear, 11 toggle.
- `req_ready` output, 1 bit: block can accept a command.
- `q_fb` input, 1 bit: `q` from `sr_ff`.
- `qbar_fb` input, 1 bit: `qbar` from `sr_ff`.
- `s` output, 1 bit: registered set drive to `sr_ff`.
- `r` output, 1 bit: registered reset drive to `sr_ff`.
- `busy` output, 1 bit: high in any state other than IDLE.
- `done` output, 1 bit: one-cycle pulse when a command completes, whether OK or error.
- `err` output, 1 bit: one-cycle pulse coincident with `done` when the command failed.
- `err_code` output, 2 bits: 00 none, 01 timeout, 10 feedback inconsistent (`q_fb==qbar_fb`); held until the next accept.

## Operation

- States are IDLE, DRIVE, CHECK and RESP.
- `req_ready` = (state==IDLE). A command is accepted on a cycle where `req_valid && req_ready`.
- On accept:
  - latch `target`: set→1, clear→0, toggle→~`q_fb` as sampled on the accept cycle, hold→no target.
  - clear `err_code` to 00.
- IDLE transitions:
  - hold → RESP directly. No `s`/`r` activity.
  - set, clear or toggle → DRIVE.
- DRIVE:
  - `s`=target, `r`=~target for exactly `PULSE_CYCLES` cycles. A pulse counter counts down.
  - Then go to CHECK with `s`=`r`=0.
- CHECK is evaluated every cycle:
  - if `q_fb==qbar_fb` → `err_code`=10, go to RESP.
  - else if `q_fb==target` → go to RESP.
  - else with the macro, if the CHECK cycle count reaches `TIMEOUT` → `err_code`=01, go to RESP.
  - Priority is inconsistency > match > timeout.
- RESP lasts one cycle:
  - `done`=1.
  - `err`=1 if `err_code`≠00.
  - Then go to IDLE.
- `s` and `r` are never high in the same cycle, under any input sequence.
- Reset values:
  - state IDLE.
  - `s`=0, `r`=0, `done`=0, `err`=0, `busy`=0.
  - `err_code`=00, `req_ready`=1, counters 0.
- Reset mid-operation:
  - any state returns to IDLE on the edge where `reset` is sampled high.
  - `s`/`r` are low from that cycle on.
  - no `done` is issued for the aborted command.
- `req_valid` while busy is ignored. It is not queued.

## Timing

- Accept at cycle N. `s` or `r` is high in cycles N+1 … N+PULSE_CYCLES.
- CHECK is first evaluated in cycle N+PULSE_CYCLES+1.
- With an ideal `sr_ff` (q updates on the edge that samples `s`/`r`), the match occurs on the first CHECK cycle. `done` is then high in cycle N+PULSE_CYCLES+2.
- Hold command: `done` is high in cycle N+1.
- Back-to-back commands: the earliest next accept is the cycle after `done`. With `PULSE_CYCLES`=1, throughput is 1 command per 4 cycles.
- Timeout: `err_code` is set after `TIMEOUT` cycles in CHECK. `done`/`err` follow one cycle later.

## Configuration

- Macro: `SR_DRV_TIMEOUT_EN`.
- Defined:
  - the CHECK cycle counter and timeout exit are compiled in.
  - `err_code`=01 is reachable.
- Undefined:
  - no counter.
  - CHECK waits indefinitely for a match or an inconsistency.
  - `err_code` is only ever 00 or 10.
  - `TIMEOUT` is unused.

## Test plan

- Reset held 5 cycles, then released → `s`=`r`=0, `req_ready`=1, `busy`=0, `err_code`=00 on the first cycle after release.
- Set request (`req_op`=01) accepted at cycle N with a real `sr_ff`, `PULSE_CYCLES`=1 → `s`=1 only in N+1, `q`=1, `done`=1 and `err`=0 in N+3.
- Toggle with `q`=1, then toggle again → first `r` pulse gives `q`=0; second `s` pulse gives `q`=1; two `done` pulses, no errors.
- Macro defined, `TIMEOUT`=4, feedback stuck at `q_fb`=0, `qbar_fb`=1, set request → `err_code`=01, `done`=`err`=1, 4 cycles after CHECK entry + 1.
- Force `q_fb`=`qbar_fb`=1 during CHECK → `err_code`=10, `err` pulse. Separately, assert `reset` during DRIVE → `s` drops and no `done` is issued.
- Random `req_valid`/`req_op` for 2000 cycles → `s&r` never 1; every accept gets exactly one `done`.
